dac_update_scheduler: RTL and testbench

- Round-robin scheduler that shares one DAC code path between NUM_REQ requesters, e.g. DDS channels or calibration logic.
- Sequences each update as grant → latch code → one-cycle load strobe → settle wait → acknowledge.
- Sits between the digital DDS core and the DAC front end in chip_top.
- The DAC front end's analog output uses the mixed-signal net type: wire in synthesis, wreal in simulation.

---
 rtl/dac_update_scheduler.sv | 111 +++++++++++
 tb/tb_dac_update_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler sharing one DAC load path: grant, latch code, load strobe, settle, ack.
// Optional feature macro: DAC_RNM_MON_EN adds a real-valued dac_mon output (simulation builds only).
`ifdef DAC_RNM_MON_EN
`ifndef ANALOG_NET_TYPE
`define ANALOG_NET_TYPE real
`endif
`endif

module dac_update_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int CODE_W     = 10,
    parameter int SETTLE_CYC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*CODE_W-1:0] req_code,
    input  logic                      dac_ready,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [CODE_W-1:0]         dac_code,
    output logic                      dac_load
`ifdef DAC_RNM_MON_EN
   ,output `ANALOG_NET_TYPE           dac_mon
`endif
);

    localparam int unsigned N     = NUM_REQ;
    localparam int          SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] rr_ptr, sel, win, idx;
    logic [CNT_W-1:0] cnt;
    logic             found, go;

    assign go = en && dac_ready && (|req);

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = SEL_W'((32'(rr_ptr) + k) % N);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = LOAD;
            LOAD:    state_nx = (SETTLE_CYC > 0) ? SETTLE : DONE;
            SETTLE:  if (cnt == CNT_W'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack      = '0;
        busy     = (state != IDLE);
        dac_load = (state == LOAD);
        if (state == DONE) ack[sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
            dac_code <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    sel      <= win;
                    dac_code <= req_code[win*CODE_W +: CODE_W];
                end
                LOAD:   cnt <= CNT_W'(SETTLE_CYC);
                SETTLE: cnt <= cnt - 1'b1;
                DONE:   rr_ptr <= (sel == SEL_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef DAC_RNM_MON_EN
    localparam real VREF = 1.0;
    real mon_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 mon_q <= 0.0;
        else if (state == LOAD)  mon_q <= real'(dac_code) * VREF / (2.0 ** CODE_W);
    end

    assign dac_mon = mon_q;
`endif

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Self-checking bench for dac_update_scheduler: vector table, corner sequences, randomized model check.
module tb_dac_update_scheduler;

    localparam int N = 4;
    localparam int W = 10;
    localparam int S = 8;
    localparam logic [N*W-1:0] RR = {10'h040, 10'h030, 10'h020, 10'h010};

    logic           clk = 1'b0;
    logic           rst, en, dac_ready;
    logic [N-1:0]   req, ack;
    logic [N*W-1:0] req_code;
    logic           busy, dac_load;
    logic [W-1:0]   dac_code;

    logic [N-1:0]   req0, ack0;
    logic [N*W-1:0] code0v;
    logic           busy0, load0;
    logic [W-1:0]   dcode0;
    real            mon, mon0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dac_update_scheduler #(.NUM_REQ(N), .CODE_W(W), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .req_code(req_code),
        .dac_ready(dac_ready), .ack(ack), .busy(busy), .dac_code(dac_code),
        .dac_load(dac_load)
`ifdef DAC_RNM_MON_EN
       ,.dac_mon(mon)
`endif
    );

    dac_update_scheduler #(.NUM_REQ(N), .CODE_W(W), .SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req0), .req_code(code0v),
        .dac_ready(dac_ready), .ack(ack0), .busy(busy0), .dac_code(dcode0),
        .dac_load(load0)
`ifdef DAC_RNM_MON_EN
       ,.dac_mon(mon0)
`endif
    );

    typedef struct {
        bit             rst_before;
        logic [N-1:0]   req;
        logic [N*W-1:0] codes;
        logic [N-1:0]   exp_ack;
        logic [W-1:0]   exp_code;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Entry and exit on a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset ctrl", {busy, dac_load, ack}, '0);
        check("reset code", dac_code, '0);
    endtask

    // Entry with DUT idle on a falling edge; the next rising edge is the grant.
    task automatic run_txn(input logic [N-1:0] r, input logic [N*W-1:0] c,
                           input logic [N-1:0] ea, input logic [W-1:0] ec, input string tag);
        logic bad;
        req = r;
        req_code = c;
        @(negedge clk);
        check({tag, " load"}, {busy, dac_load, ack}, {2'b11, 4'b0});
        check({tag, " code"}, dac_code, ec);
        bad = 1'b0;
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            if (dac_load || ack != 0 || !busy) bad = 1'b1;
        end
        check({tag, " settle"}, bad, 1'b0);
        @(negedge clk);
        check({tag, " ack"}, {busy, dac_load, ack}, {2'b10, ea});
        @(negedge clk);
        check({tag, " idle"}, {busy, dac_load, ack}, '0);
    endtask

    function automatic int rr_winner(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++)
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic           seen;
        int             e, msel, mptr, w;
        logic [W-1:0]   mcode;
        logic [N-1:0]   eack;

        rst = 1'b1; en = 1'b1; dac_ready = 1'b1;
        req = '0; req_code = '0; req0 = '0; code0v = '0;
        @(negedge clk);

        tbl[0]  = '{1'b1, 4'b0001, {10'h040, 10'h030, 10'h020, 10'h155}, 4'b0001, 10'h155};
        tbl[1]  = '{1'b1, 4'b1111, RR, 4'b0001, 10'h010};
        tbl[2]  = '{1'b0, 4'b1111, RR, 4'b0010, 10'h020};
        tbl[3]  = '{1'b0, 4'b1111, RR, 4'b0100, 10'h030};
        tbl[4]  = '{1'b0, 4'b1111, RR, 4'b1000, 10'h040};
        tbl[5]  = '{1'b0, 4'b1111, RR, 4'b0001, 10'h010};
        tbl[6]  = '{1'b0, 4'b0001, RR, 4'b0001, 10'h010};
        tbl[7]  = '{1'b0, 4'b1001, RR, 4'b1000, 10'h040};
        tbl[8]  = '{1'b0, 4'b0011, RR, 4'b0001, 10'h010};
        tbl[9]  = '{1'b0, 4'b0110, RR, 4'b0010, 10'h020};
        tbl[10] = '{1'b0, 4'b1100, RR, 4'b0100, 10'h030};
        tbl[11] = '{1'b0, 4'b0001, RR, 4'b0001, 10'h010};
        tbl[12] = '{1'b0, 4'b1000, RR, 4'b1000, 10'h040};

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            run_txn(tbl[i].req, tbl[i].codes, tbl[i].exp_ack, tbl[i].exp_code, $sformatf("row%0d", i));
        end

        // Gating by en, then by dac_ready (rr_ptr is 0 here).
        en = 1'b0; req = 4'b0100; req_code = RR; seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dac_load || busy) seen = 1'b1;
        end
        check("en gate", seen, 1'b0);
        en = 1'b1;
        run_txn(4'b0100, RR, 4'b0100, 10'h030, "en release");
        dac_ready = 1'b0; req = 4'b0001; seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dac_load || busy) seen = 1'b1;
        end
        check("ready gate", seen, 1'b0);
        dac_ready = 1'b1;
        run_txn(4'b0001, RR, 4'b0001, 10'h010, "ready release");

        // Code change, req drop and en drop after grant (rr_ptr is 1).
        req = 4'b0100; req_code = RR;
        @(negedge clk);
        check("mid load", {dac_load, dac_code}, {1'b1, 10'h030});
        req_code[2*W +: W] = 10'h3FF;
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < S; i++) begin
            @(negedge clk);
            if (i == 3) en = 1'b0;
            if (dac_code != 10'h030 || ack != 0) seen = 1'b1;
        end
        check("mid hold", seen, 1'b0);
        @(negedge clk);
        check("mid ack", {ack, dac_code}, {4'b0100, 10'h030});
        en = 1'b1;
        @(negedge clk);
        check("mid idle", {busy, dac_load, ack}, '0);

        // Reset during SETTLE (rr_ptr is 3, so req0 wins).
        req = 4'b0001; req_code = RR;
        @(negedge clk);
        check("abort load", {dac_load, dac_code}, {1'b1, 10'h010});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ctrl", {busy, dac_load, ack}, '0);
        check("abort code", dac_code, '0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack != 0 || busy) seen = 1'b1;
        end
        check("abort no ack", seen, 1'b0);
        rst = 1'b0;
        run_txn(4'b1010, RR, 4'b0010, 10'h020, "post abort");
        req = '0;

        // Zero-settle instance.
        req0 = 4'b0001; code0v = {30'h0, 10'h200};
        @(negedge clk);
        check("s0 load", {load0, ack0, dcode0}, {1'b1, 4'b0000, 10'h200});
        @(negedge clk);
        check("s0 ack", {load0, ack0}, {1'b0, 4'b0001});
`ifdef DAC_RNM_MON_EN
        n_chk++;
        if (mon0 != 0.5) begin
            n_fail++;
            $display("FAIL s0 mon: got %f expected 0.5", mon0);
        end
`endif
        req0 = '0;
        @(negedge clk);
        check("s0 idle", {busy0, ack0}, '0);

        // Randomized run against a transaction-level model.
        do_reset();
        e = 0; msel = 0; mptr = 0; mcode = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            eack = (e == S + 2) ? N'(1) << msel : '0;
            check("rnd ctrl", {busy, dac_load, ack}, {(e != 0), (e == 1), eack});
            check("rnd code", dac_code, mcode);
            rst       = ($urandom % 150) == 0;
            en        = ($urandom % 8) != 0;
            dac_ready = ($urandom % 6) != 0;
            req       = N'($urandom & $urandom);
            for (int i = 0; i < N; i++) req_code[i*W +: W] = W'($urandom);
            @(posedge clk);
            if (rst) begin
                e = 0; mptr = 0; mcode = '0;
            end else if (e == 0) begin
                w = rr_winner(req, mptr);
                if (en && dac_ready && w >= 0) begin
                    msel  = w;
                    mcode = req_code[w*W +: W];
                    e     = 1;
                end
            end else if (e == S + 2) begin
                mptr = (msel + 1) % N;
                e    = 0;
            end else begin
                e++;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
